// File: rtl/text_console_ctrl.sv
// text_console_ctrl: writes ASCII codes into the 70x30 text buffer that feeds
// the VGA text renderer, owns the cursor, handles CR/Enter/backspace, clears
// row 0 when the cursor wraps off the last row, and performs a full-screen clear.
// Optional feature macro: CURSOR_BLINK_EN (adds cursor_on and a blink counter).
//
// Handshake: char_valid/char_code from the source is taken on the clock edge
// where char_valid & char_ready; char_ready is high only in IDLE with no clr_all
// pending, and char_code is latched at that edge so the source may change it after.
//
// Buffer writes are registered: the state that decides a write (WRITE, or each
// CLR_ROW/CLR_ALL cycle) loads mem_we/mem_addr/mem_wdata, so the strobe appears
// on the following cycle. mem_addr/mem_wdata hold their last value when idle.
module text_console_ctrl #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
`ifdef CURSOR_BLINK_EN
  , parameter int BLINK = 25000000
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              char_valid,
  input  logic [7:0]        char_code,
  output logic              char_ready,
  input  logic              clr_all,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [4:0]        cur_row,
  output logic [6:0]        cur_col,
  output logic              busy,
`ifdef CURSOR_BLINK_EN
  output logic              cursor_on,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);
  localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_END    = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_END = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        SPACE      = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLR_ROW, S_CLR_ALL} state_t;

  state_t              r_state, w_state_n;
  logic [4:0]          r_row, w_row_n;
  logic [6:0]          r_col, w_col_n;
  logic [7:0]          r_code;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_n;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [7:0]          r_wdata, w_wdata_n;
  logic                r_we, w_we_n;
  logic                w_accept, w_adv, w_is_nl, w_is_bs, w_is_print;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  assign w_accept   = char_valid & char_ready;
  // 0x5A is the keyboard path's Enter code, so it is a newline, not 'Z'
  assign w_is_nl    = (r_code == 8'h0D) || (r_code == 8'h5A);
  assign w_is_bs    = (r_code == 8'h08);
  assign w_is_print = (r_code >= 8'h20) && (r_code <= 8'h7E) && !w_is_nl;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // Next-state, cursor update and buffer-write decision
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_cnt_n   = r_cnt;
    w_we_n    = 1'b0;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_adv     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_all) begin
          w_state_n = S_CLR_ALL;
          w_row_n   = '0;
          w_col_n   = '0;
          w_cnt_n   = '0;
        end else if (char_valid) begin
          w_state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_n = S_IDLE;
        if (w_is_print) begin
          w_we_n    = 1'b1;
          w_addr_n  = cell_addr(r_row, r_col);
          w_wdata_n = r_code;
          if (r_col == LAST_COL) begin
            w_col_n = '0;
            w_adv   = 1'b1;
          end else begin
            w_col_n = r_col + 7'd1;
          end
        end else if (w_is_nl) begin
          w_col_n = '0;
          w_adv   = 1'b1;
        end else if (w_is_bs) begin
          if (r_col != '0) begin
            w_col_n = r_col - 7'd1;
          end else if (r_row != '0) begin
            w_col_n = LAST_COL;
            w_row_n = r_row - 5'd1;
          end
          w_we_n    = 1'b1;
          w_addr_n  = cell_addr(w_row_n, w_col_n);
          w_wdata_n = SPACE;
        end
        // Row advance; falling off the last row wraps to row 0 and clears it
        if (w_adv) begin
          if (r_row == LAST_ROW) begin
            w_row_n   = '0;
            w_cnt_n   = '0;
            w_state_n = S_CLR_ROW;
          end else begin
            w_row_n = r_row + 5'd1;
          end
        end
      end
      S_CLR_ROW, S_CLR_ALL: begin
        // Row 0 starts at address 0, so both clears just walk the counter
        w_we_n    = 1'b1;
        w_addr_n  = r_cnt;
        w_wdata_n = SPACE;
        if (r_cnt == ((r_state == S_CLR_ROW) ? ROW_END : SCREEN_END)) begin
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Cursor, clear counter, captured code and registered buffer port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_cnt   <= w_cnt_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      if (w_accept) r_code <= char_code;
    end
  end

  // Outputs derived from state
  always_comb begin
    char_ready = (r_state == S_IDLE) && !clr_all;
    busy       = (r_state != S_IDLE);
    dbg_state  = r_state;
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cur_row   = r_row;
  assign cur_col   = r_col;

`ifdef CURSOR_BLINK_EN
  logic [31:0] r_blink_cnt;
  logic        r_cursor_on;

  // Free-running blink timer; typing keeps the cursor solid and restarts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_blink_cnt <= '0;
      r_cursor_on <= 1'b1;
    end else if (w_accept) begin
      r_blink_cnt <= '0;
      r_cursor_on <= 1'b1;
    end else if (r_blink_cnt == 32'(BLINK - 1)) begin
      r_blink_cnt <= '0;
      r_cursor_on <= ~r_cursor_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  assign cursor_on = r_cursor_on;
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: directed scenarios plus random typing, with a
// cursor/screen reference model and a write scoreboard drained by a monitor.
module tb_text_console_ctrl;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              char_valid = 1'b0;
  logic [7:0]        char_code  = 8'h00;
  logic              char_ready;
  logic              clr_all    = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [4:0]        cur_row;
  logic [6:0]        cur_col;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef CURSOR_BLINK_EN
  logic              cursor_on;
`endif

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .char_valid(char_valid), .char_code(char_code), .char_ready(char_ready),
    .clr_all(clr_all),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy),
`ifdef CURSOR_BLINK_EN
    .cursor_on(cursor_on),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W+7:0] exp_q[$];   // {addr, wdata}
  int n_chk = 0;
  int n_err = 0;
  int m_row = 0;
  int m_col = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [ADDR_W+7:0] wr(input int addr, input int data);
    return {ADDR_W'(addr), 8'(data)};
  endfunction

  // Reference model: screen rules applied to the model cursor at acceptance
  task automatic model_accept(input logic [7:0] c);
    bit adv = 0;
    if (c == 8'h0D || c == 8'h5A) begin
      m_col = 0;
      adv = 1;
    end else if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back(wr(m_row * COLS + m_col, c));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        adv = 1;
      end
    end else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
      else if (m_row > 0) begin
        m_col = COLS - 1;
        m_row--;
      end
      exp_q.push_back(wr(m_row * COLS + m_col, 8'h20));
    end
    if (adv) begin
      m_row++;
      if (m_row == ROWS) begin
        m_row = 0;
        for (int k = 0; k < COLS; k++) exp_q.push_back(wr(k, 8'h20));
      end
    end
  endtask

  // Monitor: every buffer write must match the head of the expected queue
  always @(negedge clk) begin
    if (resetn && mem_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none", mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), int'(e[ADDR_W+7:8]));
        check("wr_data", int'(mem_wdata), int'(e[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_char(input logic [7:0] c);
    bit done = 0;
    @(posedge clk);
    #1;
    char_valid = 1'b1;
    char_code  = c;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (char_ready) begin
        model_accept(c);
        done = 1;
      end
    end
    if (!done) timeout("send_char");
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_code  = 8'($urandom_range(1, 255));  // code must have been captured
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    if (!done) timeout("wait_idle");
  endtask

  task automatic check_cursor(input string name);
    @(negedge clk);
    check({name, "_row"}, int'(cur_row), m_row);
    check({name, "_col"}, int'(cur_col), m_col);
  endtask

  task automatic pulse_clr_all(input bit with_char);
    @(posedge clk);
    #1;
    clr_all = 1'b1;
    if (with_char) begin
      char_valid = 1'b1;
      char_code  = 8'h51;
    end
    for (int k = 0; k < COLS * ROWS; k++) exp_q.push_back(wr(k, 8'h20));
    m_row = 0;
    m_col = 0;
    @(posedge clk);
    #1;
    clr_all    = 1'b0;
    char_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_we"}, int'(mem_we), 0);
    check({name, "_addr"}, int'(mem_addr), 0);
    check({name, "_wdata"}, int'(mem_wdata), 0);
    check({name, "_row"}, int'(cur_row), 0);
    check({name, "_col"}, int'(cur_col), 0);
    check({name, "_ready"}, int'(char_ready), 1);
    check({name, "_busy"}, int'(busy), 0);
`ifdef CURSOR_BLINK_EN
    check({name, "_cursor_on"}, int'(cursor_on), 1);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lows;
    logic [7:0] c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    #1 resetn = 1'b1;

    // 1: 'A' at home, ready drops for exactly one cycle
    send_char(8'h41);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!char_ready) lows++;
    end
    check("ready_low_cycles", lows, 1);
    wait_idle();
    check_cursor("after_A");

    // 2: fill to (0,69), 'B' wraps to next row, then CR
    for (int i = 1; i < COLS - 1; i++) send_char(8'h61 + 8'(i % 26));
    wait_idle();
    check_cursor("at_0_69");
    send_char(8'h42);
    wait_idle();
    check_cursor("after_B");
    send_char(8'h0D);
    wait_idle();
    check_cursor("after_CR");

    // 4: backspace across the row edge and at home
    pulse_clr_all(0);
    wait_idle();
    send_char(8'h0D);
    send_char(8'h08);
    wait_idle();
    check_cursor("bs_wrap");
    for (int i = 0; i < COLS - 1; i++) send_char(8'h08);
    wait_idle();
    send_char(8'h08);
    wait_idle();
    check_cursor("bs_home");

    // 3: CR on the last row clears row 0; a held char is stalled then taken
    for (int i = 0; i < ROWS - 1; i++) send_char(8'h5A);
    for (int i = 0; i < 5; i++) send_char(8'h30 + 8'(i));
    wait_idle();
    check_cursor("at_29_5");
    send_char(8'h0D);
    send_char(8'h58);
    wait_idle();
    check_cursor("after_wrap_stall");

    // 5: clr_all wins over a simultaneous char
    pulse_clr_all(1);
    wait_idle();
    check_cursor("after_clr_all");

    // random typing
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       c = 8'h0D;
        1:       c = 8'h5A;
        2:       c = 8'h08;
        3:       c = 8'($urandom_range(1, 31));
        4:       c = 8'($urandom_range(127, 255));
        default: c = 8'($urandom_range(32, 126));
      endcase
      send_char(c);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        check_cursor("rand");
      end
    end
    wait_idle();
    check_cursor("rand_end");

    // 6: reset in the middle of a full clear
    pulse_clr_all(0);
    repeat (100) @(posedge clk);
    #1 resetn = 1'b0;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk);
    #1 resetn = 1'b1;
    send_char(8'h5F);
    wait_idle();
    check_cursor("post_reset");
`ifdef CURSOR_BLINK_EN
    check("cursor_on_after_char", int'(cursor_on), 1);
`endif
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time bound
  initial begin
    #5000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
